// File: rtl/twiddle_rotator.sv
// rtl/twiddle_rotator.sv - SDF radix-2 DIF twiddle multiply stage, fixed 4-cycle latency, no backpressure.
// Define ROTATOR_SAT_EN for a saturating output stage with a sticky sat_flag; otherwise the output wraps.
module twiddle_rotator #(
    parameter int layer = 5,
    parameter int DW    = 32,
    parameter int TW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_start,
    input  logic          in_last,
    input  logic [DW-1:0] d_real,
    input  logic [DW-1:0] d_img,
    output logic          out_valid,
    output logic          out_start,
    output logic          out_last,
    output logic [DW-1:0] q_real,
`ifdef ROTATOR_SAT_EN
    output logic          sat_flag,
`endif
    output logic [DW-1:0] q_img
);
    localparam int     N    = 1 << layer;
    localparam int     HALF = N / 2;
    localparam int     KW   = (layer > 1) ? layer - 1 : 1;
    localparam int     PW   = DW + TW;
    localparam int     SW   = DW + TW + 1;
    localparam int     ONE  = 1 << (TW - 2);
    localparam longint S    = 64'sd1 << 28;
    localparam longint PI_S = 64'sd843314857;

    localparam logic signed [TW-1:0] ONE_TW = TW'(ONE);
    localparam logic signed [SW-1:0] RND    = SW'(1) << (TW - 3);

    function automatic logic [TW-1:0] to_q(input longint v);
        longint r;
        r = (v * longint'(ONE) + S / 2) >>> 28;
        return r[TW-1:0];
    endfunction

    // Twiddle table built at elaboration from Taylor series in Q28 fixed point; word = {cos, -sin}.
    function automatic logic [HALF*2*TW-1:0] build_rom();
        logic [HALF*2*TW-1:0] rom;
        longint x, c, sn, term;
        rom = '0;
        for (int k = 0; k < HALF; k++) begin
            x    = (PI_S * 2 * longint'(k)) / longint'(N);
            c    = S;
            term = S;
            for (int i = 1; i < 16; i++) begin
                term = -((((term * x) / S) * x) / S) / longint'((2 * i - 1) * (2 * i));
                c    = c + term;
            end
            sn   = x;
            term = x;
            for (int i = 1; i < 16; i++) begin
                term = -((((term * x) / S) * x) / S) / longint'((2 * i) * (2 * i + 1));
                sn   = sn + term;
            end
            rom[k*2*TW +: 2*TW] = {to_q(c), to_q(-sn)};
        end
        return rom;
    endfunction

    localparam logic [HALF*2*TW-1:0] ROM_BITS = build_rom();

    logic [2*TW-1:0] rom [HALF];
    for (genvar g = 0; g < HALF; g++) begin : g_rom
        assign rom[g] = ROM_BITS[g*2*TW +: 2*TW];
    end

    logic [layer-1:0] idx, use_idx;
    logic             sel;
    logic [KW-1:0]    k;

    assign use_idx = in_start ? '0 : idx;

    if (layer > 1) begin : g_tw
        assign sel = use_idx[layer-1];
        assign k   = use_idx[layer-2:0];
    end else begin : g_notw
        assign sel = 1'b0;
        assign k   = '0;
    end

    logic                 v1, st1, la1, sel1;
    logic signed [DW-1:0] ar1, ai1;
    logic [2*TW-1:0]      tw1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            v1   <= 1'b0;
            st1  <= 1'b0;
            la1  <= 1'b0;
            sel1 <= 1'b0;
            ar1  <= '0;
            ai1  <= '0;
            tw1  <= '0;
        end else begin
            v1  <= in_valid;
            st1 <= in_valid & in_start;
            la1 <= in_valid & in_last;
            if (in_valid) begin
                idx  <= use_idx + 1'b1;
                ar1  <= d_real;
                ai1  <= d_img;
                sel1 <= sel;
                if (sel) tw1 <= rom[k];
            end
        end
    end

    // First half-period uses W^0 through the same multipliers, which is an exact pass-through.
    logic signed [TW-1:0] wr, wi;
    assign wr = sel1 ? $signed(tw1[2*TW-1:TW]) : ONE_TW;
    assign wi = sel1 ? $signed(tw1[TW-1:0])    : '0;

    logic                 v2, st2, la2, v3, st3, la3;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] re3, im3;
    logic [DW-1:0]        q_re_n, q_im_n;

`ifdef ROTATOR_SAT_EN
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    logic signed [SW-1:0] sh_re, sh_im;
    logic                 clip_re, clip_im;

    assign sh_re   = (re3 + RND) >>> (TW - 2);
    assign sh_im   = (im3 + RND) >>> (TW - 2);
    assign clip_re = !((&sh_re[SW-1:DW-1]) | ~(|sh_re[SW-1:DW-1]));
    assign clip_im = !((&sh_im[SW-1:DW-1]) | ~(|sh_im[SW-1:DW-1]));
    assign q_re_n  = clip_re ? (sh_re[SW-1] ? MINV : MAXV) : sh_re[DW-1:0];
    assign q_im_n  = clip_im ? (sh_im[SW-1] ? MINV : MAXV) : sh_im[DW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_flag <= 1'b0;
        else if (v3 && (clip_re || clip_im)) sat_flag <= 1'b1;
    end
`else
    assign q_re_n = DW'((re3 + RND) >>> (TW - 2));
    assign q_im_n = DW'((im3 + RND) >>> (TW - 2));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2        <= 1'b0;
            st2       <= 1'b0;
            la2       <= 1'b0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
            v3        <= 1'b0;
            st3       <= 1'b0;
            la3       <= 1'b0;
            re3       <= '0;
            im3       <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
            q_real    <= '0;
            q_img     <= '0;
        end else begin
            v2        <= v1;
            st2       <= st1;
            la2       <= la1;
            v3        <= v2;
            st3       <= st2;
            la3       <= la2;
            out_valid <= v3;
            out_start <= st3;
            out_last  <= la3;
            if (v1) begin
                p_rr <= PW'(ar1) * PW'(wr);
                p_ii <= PW'(ai1) * PW'(wi);
                p_ri <= PW'(ar1) * PW'(wi);
                p_ir <= PW'(ai1) * PW'(wr);
            end
            if (v2) begin
                re3 <= SW'(p_rr) - SW'(p_ii);
                im3 <= SW'(p_ri) + SW'(p_ir);
            end
            if (v3) begin
                q_real <= q_re_n;
                q_img  <= q_im_n;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_rotator.sv
// tb/tb_twiddle_rotator.sv - scoreboard bench for twiddle_rotator (layer=5, DW=32, TW=16).
// Expected values come from real-valued cos/sin and plain integer arithmetic.
module tb_twiddle_rotator;
    localparam int N = 32;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_start = 1'b0;
    logic        in_last  = 1'b0;
    logic [31:0] d_real   = '0;
    logic [31:0] d_img    = '0;
    logic        out_valid, out_start, out_last;
    logic [31:0] q_real, q_img;
`ifdef ROTATOR_SAT_EN
    logic        sat_flag;
`endif

    always #5 clk = ~clk;

    twiddle_rotator #(.layer(5), .DW(32), .TW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_start (in_start),
        .in_last  (in_last),
        .d_real   (d_real),
        .d_img    (d_img),
        .out_valid(out_valid),
        .out_start(out_start),
        .out_last (out_last),
        .q_real   (q_real),
`ifdef ROTATOR_SAT_EN
        .sat_flag (sat_flag),
`endif
        .q_img    (q_img)
    );

    typedef struct {
        int          due;
        bit          st;
        bit          la;
        bit          clip;
        logic [31:0] re;
        logic [31:0] im;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   mi        = 0;
    bit   sat_model = 1'b0;
    exp_t mon_e;
    bit   exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] fix(input longint v, inout bit clip);
`ifdef ROTATOR_SAT_EN
        if (v > 64'sd2147483647) begin
            clip = 1'b1;
            return 32'h7fff_ffff;
        end
        if (v < -64'sd2147483648) begin
            clip = 1'b1;
            return 32'h8000_0000;
        end
`endif
        return v[31:0];
    endfunction

    function automatic void model(input int i, input logic [31:0] re_in, input logic [31:0] im_in,
                                  inout exp_t e);
        longint ar, ai, wr, wi, re, im;
        real    th;
        ar = $signed(re_in);
        ai = $signed(im_in);
        wr = 16384;
        wi = 0;
        if (i >= N / 2) begin
            th = 2.0 * 3.14159265358979323846 * (i - N / 2) / N;
            wr = longint'($floor($cos(th) * 16384.0 + 0.5));
            wi = longint'($floor(-$sin(th) * 16384.0 + 0.5));
        end
        re     = (ar * wr - ai * wi + 8192) >>> 14;
        im     = (ar * wi + ai * wr + 8192) >>> 14;
        e.clip = 1'b0;
        e.re   = fix(re, e.clip);
        e.im   = fix(im, e.clip);
    endfunction

    task automatic send(input bit st, input bit la, input logic [31:0] re, input logic [31:0] im);
        exp_t e;
        int   use_i;
        use_i = st ? 0 : mi;
        mi    = (use_i + 1) % N;
        model(use_i, re, im, e);
        e.due    = cyc + 4;
        e.st     = st;
        e.la     = la;
        in_valid = 1'b1;
        in_start = st;
        in_last  = la;
        d_real   = re;
        d_img    = im;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                mon_e = sb.pop_front();
                if (out_valid) begin
                    check("q_real", q_real, mon_e.re);
                    check("q_img", q_img, mon_e.im);
                    check("out_start", out_start, mon_e.st);
                    check("out_last", out_last, mon_e.la);
`ifdef ROTATOR_SAT_EN
                    sat_model = sat_model | mon_e.clip;
                    check("sat_flag", sat_flag, sat_model);
`endif
                end
            end
        end
    end

    initial begin
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset q_real", q_real, 0);
        check("reset q_img", q_img, 0);
        check("reset out_start", out_start, 0);
        check("reset out_last", out_last, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // constant 1000+j0 over one full period
        for (int i = 0; i < N; i++) send(i == 0, i == N - 1, 32'd1000, 32'd0);
        idle(6);

        // 3-cycle input gap at idx 10
        for (int i = 0; i < N; i++) begin
            if (i == 10) idle(3);
            send(i == 0, i == N - 1, 32'd1000 + 32'(i * 37), 32'(-i * 11));
        end
        idle(6);

        // most-negative real part rotated by -j at idx 24
        for (int i = 0; i < N; i++) send(i == 0, i == N - 1, (i == 24) ? 32'h8000_0000 : 32'd1000, 32'd0);
        idle(6);

        // in_start re-asserted at idx 7
        for (int j = 0; j < N + 7; j++) send(j == 0 || j == 7, j == N + 6, 32'd1000, 32'd250);
        idle(6);

        // 1-sample frame
        send(1'b1, 1'b1, 32'd12345, 32'hffff_f000);
        idle(6);

        // asynchronous reset mid-frame at idx 12
        for (int i = 0; i < 12; i++) send(i == 0, 1'b0, $urandom, $urandom);
        #2 rst = 1'b0;
        sb.delete();
        mi        = 0;
        sat_model = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst q_real", q_real, 0);
        check("async rst q_img", q_img, 0);
        check("async rst out_start", out_start, 0);
`ifdef ROTATOR_SAT_EN
        check("async rst sat_flag", sat_flag, 0);
`endif
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) send(i == 0, i == N - 1, 32'd1000, 32'd0);

        // random frames with random gaps
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
                send(i == 0, i == N - 1, $urandom, $urandom);
            end
        end

        for (int t = 0; t < 100 && sb.size() > 0; t++) idle(1);
        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
